sync_fifo_prog: RTL and testbench

//  Synchronous single-clock FIFO, successor to the fixed 16x8 FIFO. Adds any DEPTH>=2 (not only

---
 rtl/sync_fifo_prog_if.sv | 42 ++++
 rtl/sync_fifo_prog.sv | 116 +++++++++++
 tb/tb_sync_fifo_prog.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_prog_if.sv
// sync_fifo_prog_if: producer/consumer bundle for sync_fifo_prog.
//   master : drives data_in, wr_en, rd_en, af_level, ae_level and err_clr.
//            It observes the read data, the handshake pulses, the status flags and the level.
//   slave  : the FIFO side. The direction of every signal is the reverse of master.
// WIDTH and DEPTH must match the parameters of the sync_fifo_prog instance this bundle connects to.
interface sync_fifo_prog_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_in;
  logic             wr_en;
  logic             rd_en;
  logic [LVL_W-1:0] af_level;
  logic [LVL_W-1:0] ae_level;
  logic             err_clr;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             wr_ack;
  logic             overflow;
  logic             underflow;
  logic             ovf_sticky;
  logic             udf_sticky;
  logic             full;
  logic             empty;
  logic             almostfull;
  logic             almostempty;
  logic [LVL_W-1:0] level;

  modport master (
    output data_in, wr_en, rd_en, af_level, ae_level, err_clr,
    input  data_out, rd_valid, wr_ack, overflow, underflow, ovf_sticky, udf_sticky,
           full, empty, almostfull, almostempty, level
  );

  modport slave (
    input  data_in, wr_en, rd_en, af_level, ae_level, err_clr,
    output data_out, rd_valid, wr_ack, overflow, underflow, ovf_sticky, udf_sticky,
           full, empty, almostfull, almostempty, level
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with any DEPTH >= 2.
// It provides a fill level, run-time almost-full/almost-empty thresholds and sticky error flags.
//   clk, rst : rising-edge clock, synchronous active-high reset (reset wins over all requests)
//   bus_io   : sync_fifo_prog_if.slave bundle. It carries:
//              - the write/read requests and the thresholds
//              - err_clr
//              - the read data and rd_valid
//              - the wr_ack, overflow and underflow pulses
//              - the sticky error flags
//              - full, empty, almostfull, almostempty and level
// Build option: define FIFO_FWFT_EN for first-word fall-through reads.
//   In that mode data_out shows the head word combinationally, and rd_valid = !empty.
//   Without FIFO_FWFT_EN, a read has one cycle of latency and rd_valid pulses when the word arrives.
module sync_fifo_prog #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_prog_if.slave bus_io
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] LvlMax = LVL_W'(DEPTH);
  localparam logic [PTR_W-1:0] PtrMax = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wr_ack_q, overflow_q, underflow_q;
  logic             ovf_sticky_q, ovf_sticky_d, udf_sticky_q, udf_sticky_d;
  logic             wacc, racc, ovf_ev, udf_ev;

  // Acceptance is judged on the pre-edge level only.
  // A write at full is refused even if a read frees a slot in the same cycle, and vice versa.
  assign wacc   = bus_io.wr_en && (level_q != LvlMax);
  assign racc   = bus_io.rd_en && (level_q != '0);
  assign ovf_ev = bus_io.wr_en && !wacc;
  assign udf_ev = bus_io.rd_en && !racc;

  always_comb begin
    level_d = level_q;
    case ({wacc, racc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // DEPTH need not be a power of two, so the pointers wrap by explicit compare.
    wr_ptr_d = wr_ptr_q;
    if (wacc) wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (racc) rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
    // Setting a flag takes priority over clearing it in the same cycle.
    ovf_sticky_d = ovf_ev ? 1'b1 : (bus_io.err_clr ? 1'b0 : ovf_sticky_q);
    udf_sticky_d = udf_ev ? 1'b1 : (bus_io.err_clr ? 1'b0 : udf_sticky_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      wr_ack_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      wr_ack_q     <= wacc;
      overflow_q   <= ovf_ev;
      underflow_q  <= udf_ev;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  // Storage is not reset. A reset cycle must not write, so the write is gated by reset.
  always_ff @(posedge clk) begin
    if (!rst && wacc) mem_q[wr_ptr_q] <= bus_io.data_in;
  end

`ifdef FIFO_FWFT_EN
  assign bus_io.data_out = mem_q[rd_ptr_q];
  assign bus_io.rd_valid = (level_q != '0);
`else
  logic [WIDTH-1:0] data_out_q;
  logic             rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (racc) data_out_q <= mem_q[rd_ptr_q];
      rd_valid_q <= racc;
    end
  end

  assign bus_io.data_out = data_out_q;
  assign bus_io.rd_valid = rd_valid_q;
`endif

  assign bus_io.wr_ack      = wr_ack_q;
  assign bus_io.overflow    = overflow_q;
  assign bus_io.underflow   = underflow_q;
  assign bus_io.ovf_sticky  = ovf_sticky_q;
  assign bus_io.udf_sticky  = udf_sticky_q;
  assign bus_io.level       = level_q;
  assign bus_io.full        = (level_q == LvlMax);
  assign bus_io.empty       = (level_q == '0);
  assign bus_io.almostfull  = (level_q >= bus_io.af_level);
  assign bus_io.almostempty = (level_q <= bus_io.ae_level);
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Randomised scoreboard bench for sync_fifo_prog (DEPTH=6, WIDTH=16).
// A queue-based reference model is stepped after every clock edge. A monitor samples on the
// falling edge and compares each output against the model.
module tb_sync_fifo_prog;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_prog_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  // Reference model state
  logic [WIDTH-1:0] model_q [$];  // FIFO contents, head at index 0
  logic [WIDTH-1:0] exp_q [$];    // words expected on data_out (registered-read mode)
  bit   m_ack, m_ovf, m_udf, m_osti, m_usti, m_rv;
  bit   started = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   max_level = 0;
  logic [WIDTH-1:0] last_data = '0;
  logic [WIDTH-1:0] next_word = 16'h0001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advances the model by one clock edge, using the inputs that were applied at that edge.
  task automatic model_edge();
    bit wacc, racc;
    if (rst) begin
      model_q.delete();
      exp_q.delete();
      {m_ack, m_ovf, m_udf, m_osti, m_usti, m_rv} = '0;
      last_data = '0;
    end else begin
      wacc = bus.wr_en && (model_q.size() < DEPTH);
      racc = bus.rd_en && (model_q.size() > 0);
      if (racc) exp_q.push_back(model_q.pop_front());
      if (wacc) model_q.push_back(bus.data_in);
      m_ack  = wacc;
      m_ovf  = bus.wr_en && !wacc;
      m_udf  = bus.rd_en && !racc;
      m_rv   = racc;
      m_osti = m_ovf ? 1'b1 : (bus.err_clr ? 1'b0 : m_osti);
      m_usti = m_udf ? 1'b1 : (bus.err_clr ? 1'b0 : m_usti);
    end
    if (model_q.size() > max_level) max_level = model_q.size();
  endtask

  task automatic step(input bit r, input bit w, input bit rd, input bit clr);
    rst         = r;
    bus.wr_en   = w;
    bus.rd_en   = rd;
    bus.err_clr = clr;
    bus.data_in = next_word;
    @(posedge clk);
    #1;
    model_edge();
    started = 1'b1;
    if (w) next_word = next_word + 1'b1;
  endtask

  // Monitor: pops from the scoreboard whenever the DUT presents a word.
  always @(negedge clk) begin
    if (started) begin
      int lvl;
      lvl = model_q.size();
      check("level", 32'(bus.level), 32'(lvl));
      check("full", 32'(bus.full), 32'(lvl == DEPTH));
      check("empty", 32'(bus.empty), 32'(lvl == 0));
      check("almostfull", 32'(bus.almostfull), 32'(lvl >= int'(bus.af_level)));
      check("almostempty", 32'(bus.almostempty), 32'(lvl <= int'(bus.ae_level)));
      check("wr_ack", 32'(bus.wr_ack), 32'(m_ack));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("underflow", 32'(bus.underflow), 32'(m_udf));
      check("ovf_sticky", 32'(bus.ovf_sticky), 32'(m_osti));
      check("udf_sticky", 32'(bus.udf_sticky), 32'(m_usti));
`ifdef FIFO_FWFT_EN
      check("rd_valid", 32'(bus.rd_valid), 32'(lvl != 0));
      if (lvl != 0) check("data_out", 32'(bus.data_out), 32'(model_q[0]));
      exp_q.delete();
`else
      check("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
      if (bus.rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard at %0t: got unexpected word %0h expected none",
                   $time, bus.data_out);
        end else begin
          last_data = exp_q.pop_front();
        end
      end
      // Whether or not a word was just read, data_out must show the most recent one.
      check("data_out", 32'(bus.data_out), 32'(last_data));
`endif
    end
  end

  initial begin
    bus.af_level = 3'd4;
    bus.ae_level = 3'd1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.err_clr = 1'b0;
    bus.data_in = '0;
    rst = 1'b1;
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);  // reset wins over requests
    // Fill past full, then drain past empty.
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    // Interleaved streaming across the pointer wrap.
    for (int i = 0; i < 40; i++) step(0, ($urandom_range(0, 2) != 0), (i % 2 == 1), 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    // Simultaneous write and read at level 3, at full and at empty.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    // Clear the sticky flags, refill, then overflow with err_clr in the same cycle.
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    // Reset at level 3.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    // Randomised phases with write/read biases, occasional clears, resets and threshold changes.
    for (int i = 0; i < 600; i++) begin
      int wb;
      wb = ((i / 60) % 2 == 0) ? 75 : 25;
      if (i % 37 == 0) begin
        bus.af_level = 3'($urandom_range(0, 7));
        bus.ae_level = 3'($urandom_range(0, 7));
      end
      next_word = 16'($urandom);
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 99) < wb),
           ($urandom_range(0, 99) >= wb - 10), ($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("max_level_bound", 32'(max_level <= DEPTH), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
